// File: rtl/icb_dma_initiator_pkg.sv
// Shared constants for the ICB block-copy initiator: FSM encodings, bus widths, pointer helpers.
package icb_dma_initiator_pkg;

   localparam int ADDR_W = 32;
   localparam int BUS_W  = 32;

   localparam logic [2:0] DMA_ST_IDLE   = 3'd0;
   localparam logic [2:0] DMA_ST_RD_CMD = 3'd1;
   localparam logic [2:0] DMA_ST_RD_RSP = 3'd2;
   localparam logic [2:0] DMA_ST_WR_CMD = 3'd3;
   localparam logic [2:0] DMA_ST_DONE   = 3'd4;

   localparam logic [ADDR_W-1:0] WORD_ALIGN = 32'hFFFF_FFFC;
   localparam logic [3:0]        WMASK_ALL  = 4'hF;

   // Word pointers advance by one 32-bit word and wrap naturally at 2^32.
   function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] ptr);
      return ptr + 32'd4;
   endfunction

endpackage

// File: rtl/icb_dma_initiator.sv
// ICB initiator copying cfg_len words from cfg_src to cfg_dst, one transaction in flight.
// Build option ICB_DMA_ERR_ABORT_EN: a read error ends the transfer instead of writing the bad word.
module icb_dma_initiator
   import icb_dma_initiator_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [LEN_W-1:0]  cfg_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              m_icb_cmd_valid,
   input  logic              m_icb_cmd_ready,
   output logic [ADDR_W-1:0] m_icb_cmd_addr,
   output logic              m_icb_cmd_read,
   output logic [BUS_W-1:0]  m_icb_cmd_wdata,
   output logic [3:0]        m_icb_cmd_wmask,
   input  logic              m_icb_rsp_valid,
   output logic              m_icb_rsp_ready,
   input  logic              m_icb_rsp_err,
   input  logic [BUS_W-1:0]  m_icb_rsp_rdata
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  cnt;
   logic [BUS_W-1:0]  hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= DMA_ST_IDLE;
         src_ptr <= '0;
         dst_ptr <= '0;
         cnt     <= '0;
         hold    <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            DMA_ST_IDLE: begin
               if (cfg_start) begin
                  err <= 1'b0;
                  if (cfg_len != '0) begin
                     src_ptr <= cfg_src & WORD_ALIGN;
                     dst_ptr <= cfg_dst & WORD_ALIGN;
                     cnt     <= cfg_len;
                     state   <= DMA_ST_RD_CMD;
                  end else begin
                     state   <= DMA_ST_DONE;
                  end
               end
            end
            DMA_ST_RD_CMD: begin
               if (m_icb_cmd_ready) state <= DMA_ST_RD_RSP;
            end
            DMA_ST_RD_RSP: begin
               if (m_icb_rsp_valid) begin
                  hold <= m_icb_rsp_rdata;
                  if (m_icb_rsp_err) err <= 1'b1;
`ifdef ICB_DMA_ERR_ABORT_EN
                  state <= m_icb_rsp_err ? DMA_ST_DONE : DMA_ST_WR_CMD;
`else
                  state <= DMA_ST_WR_CMD;
`endif
               end
            end
            DMA_ST_WR_CMD: begin
               // Writes are posted: the cmd handshake completes the word.
               if (m_icb_cmd_ready) begin
                  src_ptr <= next_word(src_ptr);
                  dst_ptr <= next_word(dst_ptr);
                  cnt     <= cnt - LEN_W'(1);
                  state   <= (cnt == LEN_W'(1)) ? DMA_ST_DONE : DMA_ST_RD_CMD;
               end
            end
            DMA_ST_DONE: state <= DMA_ST_IDLE;
            default:     state <= DMA_ST_IDLE;
         endcase
      end
   end

   assign busy            = (state == DMA_ST_RD_CMD) || (state == DMA_ST_RD_RSP) ||
                            (state == DMA_ST_WR_CMD);
   assign done            = (state == DMA_ST_DONE);
   assign m_icb_cmd_valid = (state == DMA_ST_RD_CMD) || (state == DMA_ST_WR_CMD);
   assign m_icb_cmd_read  = (state == DMA_ST_RD_CMD);
   assign m_icb_cmd_addr  = (state == DMA_ST_WR_CMD) ? dst_ptr : src_ptr;
   assign m_icb_cmd_wdata = hold;
   assign m_icb_cmd_wmask = WMASK_ALL;
   // Write responses are never awaited, so any rsp outside RD_RSP just drains.
   assign m_icb_rsp_ready = 1'b1;

endmodule

// File: tb/tb_icb_dma_initiator.sv
// Scoreboard bench for icb_dma_initiator with a zero-wait ICB memory slave model.
module tb_icb_dma_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_src = '0;
   logic [31:0] cfg_dst = '0;
   logic [15:0] cfg_len = '0;
   logic        busy, done, err;
   logic        cmd_valid, cmd_ready, cmd_read;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   icb_dma_initiator #(.LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
      .busy(busy), .done(done), .err(err),
      .m_icb_cmd_valid(cmd_valid), .m_icb_cmd_ready(cmd_ready),
      .m_icb_cmd_addr(cmd_addr), .m_icb_cmd_read(cmd_read),
      .m_icb_cmd_wdata(cmd_wdata), .m_icb_cmd_wmask(cmd_wmask),
      .m_icb_rsp_valid(rsp_valid), .m_icb_rsp_ready(rsp_ready),
      .m_icb_rsp_err(rsp_err), .m_icb_rsp_rdata(rsp_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem [bit [31:0]];
   bit          bp_en = 1'b0;
   int          err_idx = -1;
   int          rd_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory slave: response lands in the cycle after the cmd handshake.
   initial begin : slave
      logic hs, rd;
      logic [31:0] a, wd;
      cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
      forever begin
         @(negedge clk);
         hs = cmd_valid && cmd_ready && rst_n;
         rd = cmd_read; a = cmd_addr; wd = cmd_wdata;
         @(posedge clk); #1;
         rsp_valid = hs; rsp_err = 1'b0; rsp_rdata = '0;
         if (hs) begin
            if (rd) begin
               rsp_rdata = mem.exists(a) ? mem[a] : 32'hDEAD_0000;
               if (rd_cnt == err_idx) rsp_err = 1'b1;
               rd_cnt++;
            end else begin
               mem[a] = wd;
            end
         end
         cmd_ready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
      end
   end

   // Monitor: pops one expected command per handshake and checks stall stability.
   initial begin : monitor
      bit   stalled;
      txn_t held, got, e;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         got.rd = cmd_read; got.addr = cmd_addr; got.wdata = cmd_read ? 32'h0 : cmd_wdata;
         if (rst_n && cmd_valid) begin
            if (stalled) begin
               n_cmp++;
               if (got !== held) begin
                  n_bad++;
                  $display("FAIL stall_stable: got %h expected %h", got, held);
               end
            end
            if (cmd_ready) begin
               stalled = 1'b0;
               n_cmp++;
               if (cmd_wmask !== 4'hF) begin
                  n_bad++;
                  $display("FAIL wmask: got %h expected f", cmd_wmask);
               end else if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_cmd: got rd=%0b addr=%h expected no command", got.rd, got.addr);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     n_bad++;
                     $display("FAIL cmd: got rd=%0b addr=%h wdata=%h expected rd=%0b addr=%h wdata=%h",
                              got.rd, got.addr, got.wdata, e.rd, e.addr, e.wdata);
                  end
               end
            end else begin
               stalled = 1'b1;
               held = got;
            end
         end else begin
            if (stalled && rst_n) begin
               n_cmp++; n_bad++;
               $display("FAIL valid_drop: got cmd_valid=0 expected 1 while stalled");
            end
            stalled = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ a;
   endfunction

   task automatic fill(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = pat(base + 32'(4 * i));
   endtask

   task automatic push_rd(input logic [31:0] a);
      exp_q.push_back('{rd: 1'b1, addr: a, wdata: 32'h0});
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back('{rd: 1'b0, addr: a, wdata: d});
   endtask

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         push_rd(s + 32'(4 * i));
         push_wr(d + 32'(4 * i), pat(s + 32'(4 * i)));
      end
   endtask

   // Leaves the bench at the negedge one cycle after the start edge.
   task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      @(negedge clk);
      cfg_start = 1'b1; cfg_src = s; cfg_dst = d; cfg_len = l;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int max, output int cyc);
      cyc = cyc0;
      while (!done && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      end
   endtask

   task automatic settle(input string nm);
      repeat (3) @(negedge clk);
      check(nm, exp_q.size(), 0);
   endtask

   initial begin : stim
      int cyc;
      #12;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
      check("rst_cmd_read", {31'd0, cmd_read}, 0);
      check("rst_cmd_addr", cmd_addr, 0);
      check("rst_cmd_wdata", cmd_wdata, 0);
      @(negedge clk); rst_n = 1'b1;

      // T1: four-word copy, zero-wait slave
      fill(32'h100, 4);
      push_copy(32'h100, 32'h200, 4);
      start_xfer(32'h100, 32'h200, 16'd4);
      wait_done(1, 60, cyc);
      check("t1_done_cycle", cyc, 13);
      check("t1_busy_at_done", {31'd0, busy}, 0);
      @(negedge clk);
      check("t1_done_pulse", {31'd0, done}, 0);
      for (int i = 0; i < 4; i++)
         check("t1_mem", mem[32'h200 + 32'(4 * i)], pat(32'h100 + 32'(4 * i)));
      check("t1_err", {31'd0, err}, 0);
      settle("t1_queue");

      // T2: zero-length transfer
      start_xfer(32'h100, 32'h300, 16'd0);
      wait_done(1, 10, cyc);
      check("t2_done_cycle", cyc, 1);
      check("t2_busy", {31'd0, busy}, 0);
      settle("t2_queue");

      // T3: eight words under random cmd_ready backpressure
      fill(32'h400, 8);
      push_copy(32'h400, 32'h600, 8);
      bp_en = 1'b1;
      start_xfer(32'h400, 32'h600, 16'd8);
      wait_done(1, 400, cyc);
      bp_en = 1'b0;
      for (int i = 0; i < 8; i++)
         check("t3_mem", mem[32'h600 + 32'(4 * i)], pat(32'h400 + 32'(4 * i)));
      settle("t3_queue");

      // T4: read error on the third word
      fill(32'h800, 4);
      rd_cnt = 0; err_idx = 2;
      push_copy(32'h800, 32'h900, 2);
      push_rd(32'h808);
`ifndef ICB_DMA_ERR_ABORT_EN
      push_wr(32'h908, pat(32'h808));
      push_rd(32'h80C);
      push_wr(32'h90C, pat(32'h80C));
`endif
      start_xfer(32'h800, 32'h900, 16'd4);
      wait_done(1, 60, cyc);
`ifdef ICB_DMA_ERR_ABORT_EN
      check("t4_done_cycle", cyc, 9);
      check("t4_word3_untouched", {31'd0, mem.exists(32'h90C)}, 0);
`else
      check("t4_done_cycle", cyc, 13);
      check("t4_word3", mem[32'h90C], pat(32'h80C));
`endif
      check("t4_err", {31'd0, err}, 1);
      err_idx = -1;
      settle("t4_queue");
      check("t4_err_sticky", {31'd0, err}, 1);

      // T5: second start while busy is ignored
      fill(32'hA00, 2);
      fill(32'hC00, 5);
      push_copy(32'hA00, 32'hB00, 2);
      start_xfer(32'hA00, 32'hB00, 16'd2);
      cfg_start = 1'b1; cfg_src = 32'hC00; cfg_dst = 32'hD00; cfg_len = 16'd5;
      @(negedge clk);
      cfg_start = 1'b0;
      wait_done(2, 60, cyc);
      check("t5_done_cycle", cyc, 7);
      check("t5_err_cleared", {31'd0, err}, 0);
      settle("t5_queue");
      check("t5_no_second", {31'd0, mem.exists(32'hD00)}, 0);

      // T6: source pointer wraps past 2^32
      fill(32'hFFFF_FFF8, 3);
      push_copy(32'hFFFF_FFF8, 32'h300, 3);
      start_xfer(32'hFFFF_FFF8, 32'h300, 16'd3);
      wait_done(1, 60, cyc);
      check("t6_done_cycle", cyc, 10);
      check("t6_mem_wrap", mem[32'h308], pat(32'h0));
      settle("t6_queue");

      // T6b: asynchronous reset while the first read response is pending
      push_rd(32'h1000);
      start_xfer(32'h1000, 32'h2000, 16'd4);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("ar_busy", {31'd0, busy}, 0);
      check("ar_done", {31'd0, done}, 0);
      check("ar_err", {31'd0, err}, 0);
      check("ar_cmd_valid", {31'd0, cmd_valid}, 0);
      check("ar_cmd_read", {31'd0, cmd_read}, 0);
      check("ar_cmd_addr", cmd_addr, 0);
      check("ar_cmd_wdata", cmd_wdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      settle("ar_queue");
      check("ar_no_write", {31'd0, mem.exists(32'h2000)}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
